// File: rtl/wb_write_queue_if.sv
// rtl/wb_write_queue_if.sv - writeback queue bus: producer, register-file and lookup signals
//
// Purpose : groups every handshake/bus signal of wb_write_queue.
// Ports   : in_*  writeback request from the pipeline (two ports, E older than M)
//           rf_*  head-of-queue write command towards the register file
//           lk_*  decode-stage forwarding lookup
//           count number of stored entries
// Modports: master drives requests/rf_ready/lk_src; slave is the queue.
interface wb_write_queue_if #(
   parameter int DEPTH = 4
);
   logic                   in_valid;
   logic                   in_ready;
   logic [3:0]             in_dstE;
   logic [63:0]            in_valE;
   logic [3:0]             in_dstM;
   logic [63:0]            in_valM;
   logic                   rf_we;
   logic [3:0]             rf_dst;
   logic [63:0]            rf_val;
   logic                   rf_ready;
   logic [3:0]             lk_src;
   logic                   lk_hit;
   logic [63:0]            lk_val;
   logic [$clog2(DEPTH):0] count;

   modport master (
      output in_valid, in_dstE, in_valE, in_dstM, in_valM, rf_ready, lk_src,
      input  in_ready, rf_we, rf_dst, rf_val, lk_hit, lk_val, count
   );

   modport slave (
      input  in_valid, in_dstE, in_valE, in_dstM, in_valM, rf_ready, lk_src,
      output in_ready, rf_we, rf_dst, rf_val, lk_hit, lk_val, count
   );
endinterface

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - register-file writeback queue with youngest-match forwarding lookup
//
// Purpose : buffers E/M writeback requests (E enqueued before M), drains them one
//           per rf_ready to the register file, and answers decode lookups with the
//           youngest pending value for a register.
// Ports   : clk   rising-edge clock
//           rst_n synchronous active-low reset
//           q     wb_write_queue_if.slave (request, register-file and lookup signals)
module wb_write_queue #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   wb_write_queue_if.slave  q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [3:0]    r_dst [DEPTH];
   logic [63:0]   r_val [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_ready;
   logic          w_accept;
   logic          w_push_e;
   logic          w_push_m;
   logic          w_pop;
   logic          w_nonempty;
   logic [PW-1:0] w_m_slot;
   logic [CW-1:0] w_npush;
   logic [PW-1:0] w_idx;
   logic          w_lk_hit;
   logic [63:0]   w_lk_val;

   // A request may carry two entries, so accept only with two free slots.
   assign w_ready    = (r_count <= CW'(DEPTH - 2));
   assign w_accept   = q.in_valid && w_ready;
   assign w_push_e   = w_accept && (q.in_dstE != 4'hF);
   assign w_push_m   = w_accept && (q.in_dstM != 4'hF);
   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty && q.rf_ready;
   assign w_npush    = CW'(w_push_e) + CW'(w_push_m);
   // M lands behind E when both are written, otherwise it takes the write slot.
   assign w_m_slot   = w_push_e ? (r_wptr + PW'(1)) : r_wptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_e) begin
            r_dst[r_wptr] <= q.in_dstE;
            r_val[r_wptr] <= q.in_valE;
         end
         if (w_push_m) begin
            r_dst[w_m_slot] <= q.in_dstM;
            r_val[w_m_slot] <= q.in_valM;
         end
         r_wptr <= r_wptr + PW'(w_npush);
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         r_count <= r_count + w_npush - CW'(w_pop);
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      w_lk_hit = 1'b0;
      w_lk_val = '0;
      w_idx    = '0;
      if (q.lk_src != 4'hF) begin
         for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + PW'(i);
            if ((CW'(i) < r_count) && (r_dst[w_idx] == q.lk_src)) begin
               w_lk_hit = 1'b1;
               w_lk_val = r_val[w_idx];
            end
         end
      end
   end

   assign q.in_ready = w_ready;
   assign q.rf_we    = w_nonempty;
   assign q.rf_dst   = w_nonempty ? r_dst[r_rptr] : 4'h0;
   assign q.rf_val   = w_nonempty ? r_val[r_rptr] : 64'h0;
   assign q.lk_hit   = w_lk_hit;
   assign q.lk_val   = w_lk_val;
   assign q.count    = r_count;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - self-checking bench for wb_write_queue
module tb_wb_write_queue;
   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0]  dst;
      logic [63:0] val;
   } ent_t;

   typedef struct {
      logic        iv;
      logic [3:0]  de;
      logic [63:0] ve;
      logic [3:0]  dm;
      logic [63:0] vm;
      logic        rr;
      logic [3:0]  lk;
      int          cnt;
      logic        we;
      logic [3:0]  dst;
      logic [63:0] val;
      logic        rdy;
      logic        hit;
      logic [63:0] lv;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;
   ent_t sb[$];
   ent_t wr_log[$];

   wb_write_queue_if #(.DEPTH(DEPTH)) bus ();

   wb_write_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm, input logic rr,
                        input logic [3:0] lk);
      bus.in_valid = iv;
      bus.in_dstE  = de;
      bus.in_valE  = ve;
      bus.in_dstM  = dm;
      bus.in_valM  = vm;
      bus.rf_ready = rr;
      bus.lk_src   = lk;
   endtask

   // Compare every observable output against the scoreboard model.
   task automatic sb_check();
      ent_t        h;
      logic        hit;
      logic [63:0] lv;
      hit = 1'b0;
      lv  = '0;
      h.dst = 4'h0;
      h.val = 64'h0;
      if (sb.size() != 0) h = sb[0];
      if (bus.lk_src != 4'hF) begin
         foreach (sb[i]) begin
            if (sb[i].dst == bus.lk_src) begin
               hit = 1'b1;
               lv  = sb[i].val;
            end
         end
      end
      chk("sb_rf_we", 64'(bus.rf_we), 64'(sb.size() != 0));
      chk("sb_rf_dst", 64'(bus.rf_dst), 64'(h.dst));
      chk("sb_rf_val", bus.rf_val, h.val);
      chk("sb_count", 64'(bus.count), 64'(sb.size()));
      chk("sb_in_ready", 64'(bus.in_ready), 64'(sb.size() <= DEPTH - 2));
      chk("sb_lk_hit", 64'(bus.lk_hit), 64'(hit));
      chk("sb_lk_val", bus.lk_val, lv);
   endtask

   task automatic step();
      logic acc;
      logic pop;
      ent_t e;
      ent_t m;
      e.dst = bus.in_dstE;
      e.val = bus.in_valE;
      m.dst = bus.in_dstM;
      m.val = bus.in_valM;
      acc = rst_n && bus.in_valid && (sb.size() <= DEPTH - 2);
      pop = rst_n && (sb.size() != 0) && bus.rf_ready;
      if (rst_n && bus.rf_we && bus.rf_ready) begin
         ent_t w;
         w.dst = bus.rf_dst;
         w.val = bus.rf_val;
         wr_log.push_back(w);
      end
      @(posedge clk);
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (pop) void'(sb.pop_front());
         if (acc && e.dst != 4'hF) sb.push_back(e);
         if (acc && m.dst != 4'hF) sb.push_back(m);
      end
      #1;
      sb_check();
   endtask

   initial begin
      vec_t tbl[14];
      int   mark;
      int   maxc;

      tbl[0]  = '{1'b1, 4'h4, 64'hA,  4'h4, 64'hB,  1'b0, 4'h4, 2, 1'b1, 4'h4, 64'hA,  1'b1, 1'b1, 64'hB};
      tbl[1]  = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b0, 4'h4, 2, 1'b1, 4'h4, 64'hA,  1'b1, 1'b1, 64'hB};
      tbl[2]  = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b1, 4'h4, 1, 1'b1, 4'h4, 64'hB,  1'b1, 1'b1, 64'hB};
      tbl[3]  = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b1, 4'h4, 0, 1'b0, 4'h0, 64'h0,  1'b1, 1'b0, 64'h0};
      tbl[4]  = '{1'b1, 4'hF, 64'h5,  4'hF, 64'h6,  1'b0, 4'hF, 0, 1'b0, 4'h0, 64'h0,  1'b1, 1'b0, 64'h0};
      tbl[5]  = '{1'b1, 4'h1, 64'h10, 4'h2, 64'h20, 1'b0, 4'h2, 2, 1'b1, 4'h1, 64'h10, 1'b1, 1'b1, 64'h20};
      tbl[6]  = '{1'b1, 4'h3, 64'h30, 4'h1, 64'h40, 1'b0, 4'h1, 4, 1'b1, 4'h1, 64'h10, 1'b0, 1'b1, 64'h40};
      tbl[7]  = '{1'b1, 4'h5, 64'h50, 4'h6, 64'h60, 1'b0, 4'h5, 4, 1'b1, 4'h1, 64'h10, 1'b0, 1'b0, 64'h0};
      tbl[8]  = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b1, 4'h1, 3, 1'b1, 4'h2, 64'h20, 1'b0, 1'b1, 64'h40};
      tbl[9]  = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b1, 4'h1, 2, 1'b1, 4'h3, 64'h30, 1'b1, 1'b1, 64'h40};
      tbl[10] = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b1, 4'h3, 1, 1'b1, 4'h1, 64'h40, 1'b1, 1'b0, 64'h0};
      tbl[11] = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b1, 4'h1, 0, 1'b0, 4'h0, 64'h0,  1'b1, 1'b0, 64'h0};
      tbl[12] = '{1'b1, 4'hF, 64'h0,  4'h7, 64'h70, 1'b0, 4'hF, 1, 1'b1, 4'h7, 64'h70, 1'b1, 1'b0, 64'h0};
      tbl[13] = '{1'b0, 4'hF, 64'h0,  4'hF, 64'h0,  1'b1, 4'h7, 0, 1'b0, 4'h0, 64'h0,  1'b1, 1'b0, 64'h0};

      // Reset state
      rst_n = 1'b0;
      drive(1'b1, 4'h2, 64'h22, 4'h3, 64'h33, 1'b1, 4'h2);
      step();
      step();
      chk("reset_count", 64'(bus.count), 64'd0);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
      chk("reset_lk_hit", 64'(bus.lk_hit), 64'd0);
      rst_n = 1'b1;
      drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b0, 4'hF);
      step();

      // Table: ordering/duplicates, no-write filter, full/backpressure, lookup
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].iv, tbl[i].de, tbl[i].ve, tbl[i].dm, tbl[i].vm, tbl[i].rr, tbl[i].lk);
         step();
         chk($sformatf("tbl%0d_count", i), 64'(bus.count), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d_rf_we", i), 64'(bus.rf_we), 64'(tbl[i].we));
         chk($sformatf("tbl%0d_rf_dst", i), 64'(bus.rf_dst), 64'(tbl[i].dst));
         chk($sformatf("tbl%0d_rf_val", i), bus.rf_val, tbl[i].val);
         chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].rdy));
         chk($sformatf("tbl%0d_lk_hit", i), 64'(bus.lk_hit), 64'(tbl[i].hit));
         chk($sformatf("tbl%0d_lk_val", i), bus.lk_val, tbl[i].lv);
      end

      // Basic drain with one-cycle latency
      drive(1'b1, 4'h3, 64'h11, 4'hF, 64'h0, 1'b1, 4'hF);
      step();
      chk("drain_rf_we", 64'(bus.rf_we), 64'd1);
      chk("drain_rf_dst", 64'(bus.rf_dst), 64'd3);
      chk("drain_rf_val", bus.rf_val, 64'h11);
      drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 4'hF);
      step();
      chk("drain_empty_we", 64'(bus.rf_we), 64'd0);
      chk("drain_empty_count", 64'(bus.count), 64'd0);

      // Wrap with simultaneous push and pop
      mark = wr_log.size();
      maxc = 0;
      for (int k = 0; k < 12; k++) begin
         int d;
         d = (k % 6) + 1;
         if (k % 2 == 0) drive(1'b1, 4'(d), 64'(256 + d), 4'hF, 64'h0, 1'b1, 4'(d));
         else            drive(1'b1, 4'hF, 64'h0, 4'(d), 64'(256 + d), 1'b1, 4'(d));
         step();
         if (int'(bus.count) > maxc) maxc = int'(bus.count);
      end
      drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 4'hF);
      for (int k = 0; k < 3; k++) step();
      chk("wrap_max_count_le2", 64'(maxc <= 2), 64'd1);
      chk("wrap_write_count", 64'(wr_log.size() - mark), 64'd12);
      for (int k = 0; k < 12; k++) begin
         int d;
         d = (k % 6) + 1;
         if (mark + k < wr_log.size()) begin
            chk($sformatf("wrap_dst%0d", k), 64'(wr_log[mark + k].dst), 64'(d));
            chk($sformatf("wrap_val%0d", k), wr_log[mark + k].val, 64'(256 + d));
         end
      end

      // Reset mid-operation discards pending entries
      drive(1'b1, 4'h8, 64'h80, 4'h9, 64'h90, 1'b0, 4'h8);
      step();
      drive(1'b1, 4'hA, 64'hA0, 4'hF, 64'h0, 1'b0, 4'h8);
      step();
      chk("midrst_pre_count", 64'(bus.count), 64'd3);
      rst_n = 1'b0;
      drive(1'b1, 4'hB, 64'hB0, 4'hF, 64'h0, 1'b0, 4'h8);
      step();
      chk("midrst_count", 64'(bus.count), 64'd0);
      chk("midrst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("midrst_lk_hit", 64'(bus.lk_hit), 64'd0);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      rst_n = 1'b1;
      mark = wr_log.size();
      drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 4'h9);
      for (int k = 0; k < 4; k++) step();
      chk("midrst_no_writes", 64'(wr_log.size() - mark), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count, power of two, minimum 4, all pointer and count logic sized from it.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  writeback request present this cycle.
REQ-005 in_ready  output  1  queue can accept a full request, two entries.
REQ-006 in_dstE  input  4  E-port destination register; 4'hF means no write.
REQ-007 in_valE  input  64  E-port data.
REQ-008 in_dstM  input  4  M-port destination register; 4'hF means no write.
REQ-009 in_valM  input  64  M-port data.
REQ-010 rf_we  output  1  register-file write command valid.
REQ-011 rf_dst  output  4  register-file write index, head entry.
REQ-012 rf_val  output  64  register-file write data, head entry.
REQ-013 rf_ready  input  1  register file accepts the write this cycle.
REQ-014 lk_src  input  4  decode-stage lookup register index.
REQ-015 lk_hit  output  1  a pending entry targets lk_src.
REQ-016 lk_val  output  64  data of youngest pending entry matching lk_src.
REQ-017 count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-018 Accept occurs at a rising edge with rst_n=1, in_valid=1 and in_ready=1; in_valid with in_ready=0 SHALL be ignored, with no partial enqueue.
REQ-019 On accept, an E entry is enqueued if in_dstE!=4'hF, then an M entry if in_dstM!=4'hF, E older than M; 0, 1 or 2 entries per accept.
REQ-020 in_dstE==in_dstM, not 4'hF: both enqueued in order, so the M value is the final register-file contents.
REQ-021 in_ready SHALL be combinational: 1 when count <= DEPTH-2, else 0.
REQ-022 in_ready SHALL NOT depend on rf_ready or on a same-cycle pop.
REQ-023 rf_we SHALL equal (count != 0); rf_dst/rf_val SHALL present the head entry, and SHALL be 0 when empty.
REQ-024 Pop occurs at a rising edge with rf_we=1 and rf_ready=1; exactly one entry is removed per pop.
REQ-025 Head entry SHALL remain stable while rf_we=1 and rf_ready=0.
REQ-026 Same-edge push and pop: count_next = count + pushed - popped.
REQ-026a Push and pop on the same edge SHALL preserve FIFO order.
REQ-026b Pushing into an empty queue SHALL present that entry on rf_* the following cycle, giving 1-cycle latency.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-028 Lookup SHALL be combinational over stored entries only; entries being enqueued on the current edge are excluded.
REQ-029 On a lookup match, lk_hit=1 and lk_val SHALL be the youngest matching entry.
REQ-030 lk_src==4'hF or no match: lk_hit=0, lk_val=0.
REQ-031 An entry popped on an edge SHALL NOT match lookups after that edge.

Reset
REQ-032 rst_n=0 at a rising edge: count=0, pointers=0, all stored entries invalidated; takes priority over simultaneous accept/pop.
REQ-033 During and after reset: rf_we=0, rf_dst=0, rf_val=0, lk_hit=0, lk_val=0, in_ready=1.
REQ-034 Reset mid-operation SHALL discard pending entries with no rf_we pulse for them.

Verification
REQ-035 Basic drain: rf_ready=1; accept dstE=3 valE=0x11, dstM=F -> next cycle rf_we=1 rf_dst=3 rf_val=0x11; cycle after: rf_we=0, count=0.
REQ-036 Order and duplicates: rf_ready=0; accept dstE=4 valE=0xA, dstM=4 valM=0xB -> count=2, lk_src=4 gives lk_hit=1 lk_val=0xB. Then rf_ready=1 -> writes (4,0xA) then (4,0xB).
REQ-037 Full/backpressure: DEPTH=4, rf_ready=0; accept two dual requests -> count=4, in_ready=0. A third in_valid is ignored and count stays 4. One pop -> count=3, in_ready=0; second pop -> in_ready=1.
REQ-038 Wrap and simultaneous push/pop: rf_ready=1, in_valid=1 with alternating single writes dst=1..6, vals 0x101..0x106 for 12 cycles -> register-file sees all in order, count never >2, pointers wrap with no loss.
REQ-039 Reset mid-operation: count=3 with rf_ready=0, assert rst_n=0 for one edge together with in_valid=1 -> count=0, rf_we=0, lk_hit=0, in_ready=1; no queued entry is ever written.
REQ-040 No-write filter: accept dstE=F, dstM=F -> count unchanged, rf_we unchanged; lk_src=F always gives lk_hit=0.
